// File: rtl/ttfs_tinyodin_charge_core.sv
// TTFS tinyODIN charge core: spike, neuron and synapse memories plus a control
// register behind one OBI slave port, with a slot-stepping accumulate/fire FSM.

package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module ttfs_tinyodin_charge_core #(
  parameter int  N     = 256,
  parameter type req_t = obi_pkg::obi_req_t,
  parameter type rsp_t = obi_pkg::obi_resp_t
) (
  input  logic CLK,
  input  logic RSTN,
  input  req_t tinyODIN_slave_req_i,
  output rsp_t tinyODIN_slave_resp_o
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SCAN_RD,
    S_SCAN_BYTE,
    S_SCAN_NEXT,
    S_ACC_SRD,
    S_ACC_NRD,
    S_ACC_NWR,
    S_FIRE_RD,
    S_FIRE_CHK,
    S_DONE
  } state_t;

  localparam logic [1:0] REG_SPIKE  = 2'b00;
  localparam logic [1:0] REG_NEURON = 2'b01;
  localparam logic [1:0] REG_SYN    = 2'b10;
  localparam logic [1:0] REG_CTRL   = 2'b11;

  logic [31:0] spike_mem  [64];
  logic [31:0] neuron_mem [N];
  logic [31:0] syn_mem    [8192];

  logic [31:0] spike_q, neuron_q, syn_q;

  state_t      state;
  logic [7:0]  t_end, run_end, t;
  logic        done;
  logic [5:0]  scan_word;
  logic [1:0]  scan_k;
  logic [7:0]  pre, post;
  logic [4:0]  word_j;
  logic [2:0]  nib_i;

  logic        rvalid_q, rwe_q;
  logic [1:0]  rsel_q;
  logic [31:0] ctrl_rdata_q;

  logic [1:0]  region;
  logic        idle, gnt, bus_wr, bus_rd;
  logic        unused_bits;

  logic        spike_re, spike_we, neuron_re, neuron_we, syn_re, syn_we;
  logic [5:0]  spike_addr;
  logic [7:0]  neuron_addr;
  logic [12:0] syn_addr;
  logic [31:0] spike_wdata, neuron_wdata;

  logic [3:0]  weight;
  logic [12:0] acc_sum;
  logic [11:0] acc_v;
  logic [7:0]  scan_byte, fire_byte, fire_time, t_next;
  logic        fire_now;
  logic [31:0] fire_word;

  assign region      = tinyODIN_slave_req_i.addr[21:20];
  assign idle        = (state == S_IDLE);
  assign gnt         = tinyODIN_slave_req_i.req && ((region == REG_CTRL) || idle);
  assign bus_wr      = gnt && tinyODIN_slave_req_i.we;
  assign bus_rd      = gnt && !tinyODIN_slave_req_i.we;
  assign t_next      = t + 8'd1;
  assign unused_bits = ^{tinyODIN_slave_req_i.be, tinyODIN_slave_req_i.addr[31:22],
                         tinyODIN_slave_req_i.addr[19:15], tinyODIN_slave_req_i.addr[1:0]};

  // Datapath helpers: weight accumulate with 12-bit saturation and fire decision
  always_comb begin
    weight    = syn_q[{nib_i, 2'b00} +: 4];
    acc_sum   = {neuron_q[11], neuron_q[11:0]} + {{9{weight[3]}}, weight};
    if ($signed(acc_sum) > 13'sd2047) begin
      acc_v = 12'h7FF;
    end else if ($signed(acc_sum) < -13'sd2048) begin
      acc_v = 12'h800;
    end else begin
      acc_v = acc_sum[11:0];
    end
    scan_byte = spike_q[{scan_k, 3'b000} +: 8];
    fire_byte = spike_q[{post[1:0], 3'b000} +: 8];
    fire_time = (t == 8'd255) ? 8'd255 : t_next;
    fire_now  = (fire_byte == 8'd0) &&
                ($signed({neuron_q[11], neuron_q[11:0]}) >= $signed({1'b0, neuron_q[23:12]}));
    fire_word = spike_q;
    fire_word[{post[1:0], 3'b000} +: 8] = fire_time;
  end

  // Memory port steering: the bus owns the memories in IDLE, the FSM otherwise
  always_comb begin
    spike_re     = 1'b0;
    spike_we     = 1'b0;
    spike_addr   = tinyODIN_slave_req_i.addr[7:2];
    spike_wdata  = tinyODIN_slave_req_i.wdata;
    neuron_re    = 1'b0;
    neuron_we    = 1'b0;
    neuron_addr  = tinyODIN_slave_req_i.addr[9:2];
    neuron_wdata = tinyODIN_slave_req_i.wdata;
    syn_re       = 1'b0;
    syn_we       = 1'b0;
    syn_addr     = tinyODIN_slave_req_i.addr[14:2];
    case (state)
      S_IDLE: begin
        spike_re  = bus_rd && (region == REG_SPIKE);
        spike_we  = bus_wr && (region == REG_SPIKE);
        neuron_re = bus_rd && (region == REG_NEURON);
        neuron_we = bus_wr && (region == REG_NEURON);
        syn_re    = bus_rd && (region == REG_SYN);
        syn_we    = bus_wr && (region == REG_SYN);
      end
      S_SCAN_RD: begin
        spike_re   = 1'b1;
        spike_addr = scan_word;
      end
      S_ACC_SRD: begin
        syn_re   = 1'b1;
        syn_addr = {pre, word_j};
      end
      S_ACC_NRD: begin
        neuron_re   = 1'b1;
        neuron_addr = {word_j, nib_i};
      end
      S_ACC_NWR: begin
        neuron_we    = 1'b1;
        neuron_addr  = {word_j, nib_i};
        neuron_wdata = {neuron_q[31:12], acc_v};
      end
      S_FIRE_RD: begin
        neuron_re   = 1'b1;
        neuron_addr = post;
        spike_re    = 1'b1;
        spike_addr  = post[7:2];
      end
      S_FIRE_CHK: begin
        spike_we    = fire_now;
        spike_addr  = post[7:2];
        spike_wdata = fire_word;
      end
      default: ;
    endcase
  end

  // Spike memory with registered read port
  always_ff @(posedge CLK) begin
    if (spike_we) spike_mem[spike_addr] <= spike_wdata;
    if (spike_re) spike_q <= spike_mem[spike_addr];
  end

  // Neuron memory with registered read port
  always_ff @(posedge CLK) begin
    if (neuron_we) neuron_mem[neuron_addr] <= neuron_wdata;
    if (neuron_re) neuron_q <= neuron_mem[neuron_addr];
  end

  // Synapse memory with registered read port
  always_ff @(posedge CLK) begin
    if (syn_we) syn_mem[syn_addr] <= tinyODIN_slave_req_i.wdata;
    if (syn_re) syn_q <= syn_mem[syn_addr];
  end

  // Response tracking: every grant produces rvalid on the following cycle
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      rvalid_q     <= 1'b0;
      rwe_q        <= 1'b0;
      rsel_q       <= 2'b00;
      ctrl_rdata_q <= 32'd0;
    end else begin
      rvalid_q <= gnt;
      rwe_q    <= tinyODIN_slave_req_i.we;
      rsel_q   <= region;
      if (bus_rd && (region == REG_CTRL)) ctrl_rdata_q <= {t_end, 23'd0, done};
    end
  end

  always_comb begin
    tinyODIN_slave_resp_o        = '0;
    tinyODIN_slave_resp_o.gnt    = gnt;
    tinyODIN_slave_resp_o.rvalid = rvalid_q;
    if (rvalid_q && !rwe_q) begin
      case (rsel_q)
        REG_SPIKE:  tinyODIN_slave_resp_o.rdata = spike_q;
        REG_NEURON: tinyODIN_slave_resp_o.rdata = neuron_q;
        REG_SYN:    tinyODIN_slave_resp_o.rdata = syn_q;
        default:    tinyODIN_slave_resp_o.rdata = ctrl_rdata_q;
      endcase
    end
  end

  // Control register and the scan / accumulate / fire slot sequencer
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      t_end     <= 8'd0;
      run_end   <= 8'd0;
      t         <= 8'd0;
      done      <= 1'b0;
      scan_word <= 6'd0;
      scan_k    <= 2'd0;
      pre       <= 8'd0;
      post      <= 8'd0;
      word_j    <= 5'd0;
      nib_i     <= 3'd0;
    end else begin
      case (state)
        S_SCAN_RD: begin
          scan_k <= 2'd0;
          state  <= S_SCAN_BYTE;
        end
        S_SCAN_BYTE: begin
          if (scan_byte == t) begin
            pre    <= {scan_word, scan_k};
            word_j <= 5'd0;
            state  <= S_ACC_SRD;
          end else begin
            state <= S_SCAN_NEXT;
          end
        end
        S_SCAN_NEXT: begin
          if (scan_k == 2'd3) begin
            if (scan_word == 6'd63) begin
              post  <= 8'd0;
              state <= S_FIRE_RD;
            end else begin
              scan_word <= scan_word + 6'd1;
              state     <= S_SCAN_RD;
            end
          end else begin
            scan_k <= scan_k + 2'd1;
            state  <= S_SCAN_BYTE;
          end
        end
        S_ACC_SRD: begin
          nib_i <= 3'd0;
          state <= S_ACC_NRD;
        end
        S_ACC_NRD: state <= S_ACC_NWR;
        S_ACC_NWR: begin
          if (nib_i == 3'd7) begin
            if (word_j == 5'd31) begin
              state <= S_SCAN_NEXT;
            end else begin
              word_j <= word_j + 5'd1;
              state  <= S_ACC_SRD;
            end
          end else begin
            nib_i <= nib_i + 3'd1;
            state <= S_ACC_NRD;
          end
        end
        S_FIRE_RD: state <= S_FIRE_CHK;
        S_FIRE_CHK: begin
          if (post == 8'd255) begin
            if (t_next == run_end) begin
              state <= S_DONE;
            end else begin
              t         <= t_next;
              scan_word <= 6'd0;
              state     <= S_SCAN_RD;
            end
          end else begin
            post  <= post + 8'd1;
            state <= S_FIRE_RD;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: ;
      endcase
      if (bus_wr && (region == REG_CTRL)) begin
        t_end <= tinyODIN_slave_req_i.wdata[31:24];
        if (tinyODIN_slave_req_i.wdata[10] && idle) begin
          run_end <= tinyODIN_slave_req_i.wdata[31:24];
          if (tinyODIN_slave_req_i.wdata[31:24] <= 8'd1) begin
            done <= 1'b1;
          end else begin
            done      <= 1'b0;
            t         <= 8'd1;
            scan_word <= 6'd0;
            state     <= S_SCAN_RD;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ttfs_tinyodin_charge_core.sv
// Scoreboard bench for ttfs_tinyodin_charge_core: directed OBI traffic pushes
// expected responses, a monitor pops them on every rvalid.

module tb_ttfs_tinyodin_charge_core;
  import obi_pkg::*;

  localparam int          GNT_BOUND = 20000;
  localparam logic [31:0] CTRL      = 32'h0030_0000;
  localparam logic [31:0] NEU_INIT  = 32'h00FF_F000;

  logic      clk = 1'b0;
  logic      rstn;
  obi_req_t  req;
  obi_resp_t rsp;

  int checks   = 0;
  int failures = 0;
  int last_wait;

  logic [31:0] exp_q [$];
  string       name_q [$];
  logic [31:0] mon_exp;
  string       mon_name;

  ttfs_tinyodin_charge_core dut (
    .CLK                   (clk),
    .RSTN                  (rstn),
    .tinyODIN_slave_req_i  (req),
    .tinyODIN_slave_resp_o (rsp)
  );

  // Free-running clock
  always #5 clk = ~clk;

  function automatic logic [31:0] spikeAddr(input int w);
    return 32'h0000_0000 + 32'(w * 4);
  endfunction

  function automatic logic [31:0] neuronAddr(input int n);
    return 32'h0010_0000 + 32'(n * 4);
  endfunction

  function automatic logic [31:0] synAddr(input int i);
    return 32'h0020_0000 + 32'(i * 4);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Monitor: every response is matched against the oldest outstanding expectation
  always @(negedge clk) begin
    if (rsp.rvalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_rvalid actual=%h required=no_response", rsp.rdata);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        checkOutput(mon_name, rsp.rdata, mon_exp);
      end
    end
  end

  // Issue one OBI access, wait (bounded) for gnt and queue the expected rdata
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expected,
                               input string name);
    int waited;
    @(negedge clk);
    req.req   = 1'b1;
    req.we    = we;
    req.be    = 4'hF;
    req.addr  = addr;
    req.wdata = wdata;
    #1;
    waited = 0;
    while (!rsp.gnt && waited < GNT_BOUND) begin
      @(negedge clk);
      #1;
      waited++;
    end
    last_wait = waited;
    if (!rsp.gnt) begin
      checks++;
      failures++;
      $display("[TB] FAIL gnt_timeout_%s actual=no_gnt required=gnt", name);
      req.req = 1'b0;
    end else begin
      exp_q.push_back(we ? 32'd0 : expected);
      name_q.push_back(name);
      @(posedge clk);
      #1;
      req.req = 1'b0;
    end
  endtask

  task automatic doReset();
    rstn = 1'b0;
    req  = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  task automatic initMem();
    for (int w = 0; w < 64; w++) applyStimulus(1'b1, spikeAddr(w), 32'd0, 32'd0, "init_spike");
    for (int n = 0; n < 256; n++) applyStimulus(1'b1, neuronAddr(n), NEU_INIT, 32'd0, "init_neuron");
  endtask

  task automatic clearRow(input int p);
    for (int j = 0; j < 32; j++) applyStimulus(1'b1, synAddr(p * 32 + j), 32'd0, 32'd0, "init_syn");
  endtask

  // Watchdog so the run always terminates
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    doReset();
    @(negedge clk);
    checkOutput("reset_gnt", {31'd0, rsp.gnt}, 32'd0);
    checkOutput("reset_rvalid", {31'd0, rsp.rvalid}, 32'd0);
    checkOutput("reset_rdata", rsp.rdata, 32'd0);
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0000_0000, "reset_ctrl");
    checkOutput("ctrl_gnt_wait", 32'(last_wait), 32'd0);

    // Memory write/readback in every region
    applyStimulus(1'b1, neuronAddr(5), 32'h0015_E000, 32'd0, "wr_neuron5");
    applyStimulus(1'b0, neuronAddr(5), 32'd0, 32'h0015_E000, "rd_neuron5");
    applyStimulus(1'b1, spikeAddr(3), 32'h0403_0201, 32'd0, "wr_spike3");
    applyStimulus(1'b0, spikeAddr(3), 32'd0, 32'h0403_0201, "rd_spike3");
    applyStimulus(1'b1, synAddr(8191), 32'hDEAD_BEEF, 32'd0, "wr_syn8191");
    applyStimulus(1'b0, synAddr(8191), 32'd0, 32'hDEAD_BEEF, "rd_syn8191");

    // Single excitatory synapse: pre 0 at t=1 drives post 144 over its threshold
    initMem();
    clearRow(0);
    clearRow(144);
    applyStimulus(1'b1, spikeAddr(0), 32'h0000_0001, 32'd0, "wr_spike0");
    applyStimulus(1'b1, synAddr(18), 32'h0000_0007, 32'd0, "wr_syn18");
    applyStimulus(1'b1, neuronAddr(144), 32'h0000_5000, 32'd0, "wr_neuron144");
    applyStimulus(1'b1, CTRL, 32'h0300_0400, 32'd0, "start_t3");
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0300_0000, "run_ctrl_done0");
    applyStimulus(1'b0, neuronAddr(144), 32'd0, 32'h0000_5007, "neuron144_v");
    checkOutput("busy_stall_t3", {31'd0, last_wait > 0}, 32'd1);
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0300_0001, "ctrl_done_t3");
    applyStimulus(1'b0, spikeAddr(36), 32'd0, 32'h0000_0002, "spike_word36");
    applyStimulus(1'b0, spikeAddr(0), 32'd0, 32'h0000_0001, "spike_word0_t3");

    // Negative weights across three slots, with saturation at -2048 on post 201
    initMem();
    clearRow(2);
    clearRow(3);
    clearRow(4);
    applyStimulus(1'b1, spikeAddr(0), 32'h0201_0000, 32'd0, "wr_spike0_neg");
    applyStimulus(1'b1, spikeAddr(1), 32'h0000_0003, 32'd0, "wr_spike1_neg");
    for (int p = 2; p <= 4; p++)
      applyStimulus(1'b1, synAddr(p * 32 + 25), 32'h0000_008F, 32'd0, "wr_syn_neg");
    applyStimulus(1'b1, neuronAddr(200), 32'h0000_0000, 32'd0, "wr_neuron200");
    applyStimulus(1'b1, neuronAddr(201), 32'h0000_0803, 32'd0, "wr_neuron201");
    applyStimulus(1'b1, CTRL, 32'h0400_0400, 32'd0, "start_t4");
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0400_0000, "run_ctrl_done0_neg");
    applyStimulus(1'b0, neuronAddr(200), 32'd0, 32'h0000_0FFD, "neuron200_minus3");
    checkOutput("busy_stall_t4", {31'd0, last_wait > 0}, 32'd1);
    applyStimulus(1'b0, neuronAddr(201), 32'd0, 32'h0000_0800, "neuron201_sat");
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0400_0001, "ctrl_done_t4");
    applyStimulus(1'b0, spikeAddr(50), 32'd0, 32'h0000_0000, "spike_word50_nofire");
    applyStimulus(1'b0, spikeAddr(0), 32'd0, 32'h0201_0000, "spike_word0_neg");

    // T_END of 0 and 1 finish at once without touching memory
    applyStimulus(1'b1, CTRL, 32'h0000_0400, 32'd0, "start_t0");
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0000_0001, "ctrl_done_t0");
    applyStimulus(1'b1, CTRL, 32'h0100_0400, 32'd0, "start_t1");
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0100_0001, "ctrl_done_t1");
    applyStimulus(1'b0, neuronAddr(200), 32'd0, 32'h0000_0FFD, "neuron200_unchanged");
    applyStimulus(1'b0, spikeAddr(0), 32'd0, 32'h0201_0000, "spike_word0_unchanged");

    // Writing without START only updates T_END
    applyStimulus(1'b1, CTRL, 32'h0700_0000, 32'd0, "wr_tend_only");
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0700_0001, "ctrl_tend_only");

    // Reset in the middle of a run returns to IDLE with DONE cleared
    applyStimulus(1'b1, CTRL, 32'h0400_0400, 32'd0, "start_abort");
    repeat (50) @(posedge clk);
    doReset();
    applyStimulus(1'b0, CTRL, 32'd0, 32'h0000_0000, "ctrl_after_abort");
    applyStimulus(1'b0, neuronAddr(5), 32'd0, NEU_INIT, "neuron5_after_abort");
    checkOutput("abort_idle_gnt_wait", 32'(last_wait), 32'd0);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
